// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: fetch FSM state encodings, opcode constants and two-word decode helper
package fetch_sequencer_pkg;
  typedef enum logic [2:0] {FETCH1_HI, FETCH1_LO, FETCH2_HI, FETCH2_LO, EXEC} state_t;
  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_BBL = 4'hC;
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] operand);
    return opr == OPR_JCN || opr == OPR_JUN || opr == OPR_JMS || opr == OPR_ISZ ||
           (opr == OPR_FIM && !operand[0]);
  endfunction
endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// fetch_sequencer_return_stack: wrap-around return stack; FETCH_STACK_FAULT_EN adds a sticky over/underflow fault
module fetch_sequencer_return_stack
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              fault
);
  localparam int SP_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH - 1);
  logic [SP_W-1:0] sp, sp_inc, sp_dec;
  logic [ADDR_W-1:0] entry [DEPTH];
  always_comb begin
    sp_inc = sp == SP_MAX ? '0 : sp + 1'b1;
    sp_dec = sp == '0 ? SP_MAX : sp - 1'b1;
  end
  assign pop_data = entry[sp_dec];
  always_ff @(posedge clock)
    if (!reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (push) begin
      entry[sp] <= push_data;
      sp <= sp_inc;
    end else if (pop) sp <= sp_dec;
`ifdef FETCH_STACK_FAULT_EN
  localparam int D_W = $clog2(DEPTH + 1);
  localparam logic [D_W-1:0] D_MAX = D_W'(DEPTH);
  logic [D_W-1:0] depth;
  always_ff @(posedge clock)
    if (!reset) begin
      depth <= '0;
      fault <= 1'b0;
    end else begin
      fault <= fault | (push && depth == D_MAX) | (pop && depth == '0);
      depth <= push && depth != D_MAX ? depth + 1'b1 : pop && depth != '0 ? depth - 1'b1 : depth;
    end
`else
  assign fault = 1'b0;
`endif
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: nibble-serial instruction fetch, PC and return-stack control; FETCH_STACK_FAULT_EN enables stack_fault
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic [3:0]        mem_data,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_nibble,
  input  logic              take_branch,
  input  logic              reg_is_zero,
  output logic              inst_valid,
  output logic [3:0]        inst_opr,
  output logic [3:0]        inst_operand,
  output logic [7:0]        inst_word2,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_fault
);
  state_t state, state_nxt;
  logic [3:0] stage_opr, stage_operand, stage_w2hi;
  logic [ADDR_W-1:0] pc1, pc2, pc_nxt, pop_data;
  logic fetching, ready, exec, load_inst, branch, push, pop;
  always_ff @(posedge clock)
    if (!reset) state <= FETCH1_HI;
    else state <= state_nxt;
  always_comb begin
    fetching = state != EXEC;
    ready = fetching && mem_ready && !halt;
    exec = state == EXEC && !halt;
    state_nxt = exec ? FETCH1_HI :
                !ready ? state :
                state == FETCH1_HI ? FETCH1_LO :
                state == FETCH1_LO ? (is_two_word(stage_opr, mem_data) ? FETCH2_HI : EXEC) :
                state == FETCH2_HI ? FETCH2_LO : EXEC;
  end
  always_comb begin
    mem_read = reset && !halt && fetching;
    mem_addr = state == FETCH2_HI || state == FETCH2_LO ? pc1 : pc;
    mem_nibble = state == FETCH1_LO || state == FETCH2_LO;
    inst_valid = reset && exec;
  end
  always_comb begin
    load_inst = ready && (state == FETCH2_LO || (state == FETCH1_LO && !is_two_word(stage_opr, mem_data)));
    pc1 = pc + 1'b1;
    pc2 = pc + 2'd2;
    branch = (inst_opr == OPR_JCN && take_branch) || (inst_opr == OPR_ISZ && !reg_is_zero);
    pc_nxt = inst_opr == OPR_JUN || inst_opr == OPR_JMS ? ADDR_W'({inst_operand, inst_word2}) :
             branch ? {pc2[ADDR_W-1:8], inst_word2} :
             inst_opr == OPR_BBL ? pop_data :
             is_two_word(inst_opr, inst_operand) ? pc2 : pc1;
    push = exec && inst_opr == OPR_JMS;
    pop = exec && inst_opr == OPR_BBL;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      pc <= '0;
      stage_opr <= '0;
      stage_operand <= '0;
      stage_w2hi <= '0;
      inst_opr <= '0;
      inst_operand <= '0;
      inst_word2 <= '0;
    end else begin
      if (ready && state == FETCH1_HI) stage_opr <= mem_data;
      if (ready && state == FETCH1_LO) stage_operand <= mem_data;
      if (ready && state == FETCH2_HI) stage_w2hi <= mem_data;
      if (load_inst) begin
        inst_opr <= stage_opr;
        inst_operand <= state == FETCH2_LO ? stage_operand : mem_data;
        inst_word2 <= state == FETCH2_LO ? {stage_w2hi, mem_data} : '0;
      end
      if (exec) pc <= pc_nxt;
    end
  fetch_sequencer_return_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(pc2),
    .pop_data(pop_data),
    .fault(stack_fault)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven single-instruction vectors plus stack, halt and reset sequences
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam logic EXP_FAULT =
`ifdef FETCH_STACK_FAULT_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    logic [11:0] start;
    logic [7:0]  b1, b2;
    logic        tb, rz;
    logic [3:0]  opr, opd;
    logic [7:0]  w2;
    logic [11:0] pc;
    int          cyc;
  } vec_t;
  localparam int NV = 15;
  vec_t vt[NV];
  logic clock = 0, reset = 0, halt = 0, take_branch = 0, reg_is_zero = 0;
  logic mem_ready, mem_read, mem_nibble, inst_valid, stack_fault;
  logic [3:0] mem_data, inst_opr, inst_operand;
  logic [7:0] inst_word2;
  logic [AW-1:0] mem_addr, pc;
  logic [7:0] mem [4096];
  logic ovr_en = 0, ovr_val = 0;
  int lat = 0, cnt = 0;
  int compared = 0, mismatched = 0;
  always #5 clock = ~clock;
  assign mem_ready = ovr_en ? ovr_val : (mem_read && cnt >= lat);
  assign mem_data = mem_nibble ? mem[mem_addr][3:0] : mem[mem_addr][7:4];
  always @(posedge clock) cnt <= (!reset || (mem_read && mem_ready)) ? 0 : mem_read ? cnt + 1 : cnt;
  fetch_sequencer dut (
    .clock(clock), .reset(reset), .halt(halt),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_nibble(mem_nibble),
    .take_branch(take_branch), .reg_is_zero(reg_is_zero),
    .inst_valid(inst_valid), .inst_opr(inst_opr), .inst_operand(inst_operand),
    .inst_word2(inst_word2), .pc(pc), .stack_fault(stack_fault)
  );
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_exec(output int n, input int bound);
    n = 0;
    while (!inst_valid && n < bound) begin
      step;
      n++;
    end
    if (!inst_valid) begin
      compared++;
      mismatched++;
      $display("FAIL wait_exec: no inst_valid within %0d cycles", bound);
    end
  endtask
  task automatic do_reset;
    reset = 0;
    halt = 0;
    ovr_en = 0;
    repeat (2) step;
    reset = 1;
  endtask
  initial begin
    int n;
    logic [11:0] ret [4];
    vt[0]  = '{12'h0FE, 8'h13, 8'h10, 1'b1, 1'b0, 4'h1, 4'h3, 8'h10, 12'h110, 5};
    vt[1]  = '{12'h0FE, 8'h13, 8'h10, 1'b0, 1'b0, 4'h1, 4'h3, 8'h10, 12'h100, 5};
    vt[2]  = '{12'h123, 8'h4A, 8'hBC, 1'b0, 1'b0, 4'h4, 4'hA, 8'hBC, 12'hABC, 5};
    vt[3]  = '{12'h200, 8'h72, 8'h55, 1'b0, 1'b0, 4'h7, 4'h2, 8'h55, 12'h255, 5};
    vt[4]  = '{12'h200, 8'h72, 8'h55, 1'b0, 1'b1, 4'h7, 4'h2, 8'h55, 12'h202, 5};
    vt[5]  = '{12'h300, 8'h20, 8'h99, 1'b0, 1'b0, 4'h2, 4'h0, 8'h99, 12'h302, 5};
    vt[6]  = '{12'h300, 8'h21, 8'h99, 1'b0, 1'b0, 4'h2, 4'h1, 8'h00, 12'h301, 3};
    vt[7]  = '{12'hFFF, 8'hD5, 8'h00, 1'b0, 1'b0, 4'hD, 4'h5, 8'h00, 12'h000, 3};
    vt[8]  = '{12'hFFE, 8'h1F, 8'h34, 1'b1, 1'b0, 4'h1, 4'hF, 8'h34, 12'h034, 5};
    vt[9]  = '{12'hFFE, 8'h20, 8'h11, 1'b0, 1'b0, 4'h2, 4'h0, 8'h11, 12'h000, 5};
    vt[10] = '{12'h400, 8'h51, 8'h23, 1'b0, 1'b0, 4'h5, 4'h1, 8'h23, 12'h123, 5};
    vt[11] = '{12'h500, 8'hC0, 8'h00, 1'b0, 1'b0, 4'hC, 4'h0, 8'h00, 12'h000, 3};
    vt[12] = '{12'h600, 8'h1F, 8'h77, 1'b0, 1'b0, 4'h1, 4'hF, 8'h77, 12'h602, 5};
    vt[13] = '{12'h600, 8'h1F, 8'h77, 1'b1, 1'b0, 4'h1, 4'hF, 8'h77, 12'h677, 5};
    vt[14] = '{12'h700, 8'h35, 8'hEE, 1'b0, 1'b0, 4'h3, 4'h5, 8'h00, 12'h701, 3};
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[0] = 8'hD5;
    repeat (2) step;
    chk("rst pc", pc, 0);
    chk("rst mem_read", mem_read, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_word2", inst_word2, 0);
    chk("rst stack_fault", stack_fault, 0);
    reset = 1;
    #1;
    chk("rst first read", mem_read, 1);
    chk("rst first addr", mem_addr, 0);
    chk("rst first nibble", mem_nibble, 0);
    wait_exec(n, 20);
    chk("D5 cycles", n + 1, 3);
    chk("D5 opr", inst_opr, 4'hD);
    chk("D5 operand", inst_operand, 4'h5);
    chk("D5 word2", inst_word2, 0);
    step;
    chk("D5 pc", pc, 1);
    chk("D5 opr held", inst_opr, 4'hD);
    lat = 3;
    do_reset;
    n = 0;
    while (!(mem_read && mem_nibble) && n < 30) begin
      step;
      n++;
    end
    chk("halt reach LO", mem_nibble, 1);
    halt = 1;
    #1;
    chk("halt read0 a", mem_read, 0);
    repeat (2) begin
      step;
      chk("halt read0", mem_read, 0);
      chk("halt addr", mem_addr, 0);
      chk("halt nibble", mem_nibble, 1);
    end
    halt = 0;
    #1;
    chk("halt resume read", mem_read, 1);
    wait_exec(n, 40);
    chk("halt opr", inst_opr, 4'hD);
    chk("halt operand", inst_operand, 4'h5);
    halt = 1;
    step;
    chk("exec halt valid", inst_valid, 0);
    chk("exec halt pc", pc, 0);
    halt = 0;
    #1;
    chk("exec resume valid", inst_valid, 1);
    step;
    chk("exec resume pc", pc, 1);
    mem[0] = 8'h51;
    mem[1] = 8'h23;
    mem[12'h123] = 8'hC0;
    do_reset;
    n = 0;
    while (!(mem_read && mem_addr == 1 && !mem_nibble) && n < 30) begin
      step;
      n++;
    end
    chk("rstmid reach F2HI", mem_addr, 1);
    reset = 0;
    step;
    ovr_en = 1;
    ovr_val = 1;
    step;
    reset = 1;
    ovr_en = 0;
    ovr_val = 0;
    #1;
    chk("rstmid pc", pc, 0);
    chk("rstmid addr", mem_addr, 0);
    chk("rstmid nibble", mem_nibble, 0);
    chk("rstmid valid", inst_valid, 0);
    wait_exec(n, 60);
    chk("rstmid opr", inst_opr, 4'h5);
    chk("rstmid operand", inst_operand, 4'h1);
    chk("rstmid word2", inst_word2, 8'h23);
    step;
    chk("rstmid jms pc", pc, 12'h123);
    wait_exec(n, 60);
    step;
    chk("rstmid bbl pc", pc, 12'h002);
    lat = 0;
    for (int k = 0; k < NV; k++) begin
      mem[vt[k].start] = vt[k].b1;
      mem[vt[k].start + 12'd1] = vt[k].b2;
      mem[0] = {4'h4, vt[k].start[11:8]};
      mem[1] = vt[k].start[7:0];
      take_branch = vt[k].tb;
      reg_is_zero = vt[k].rz;
      do_reset;
      wait_exec(n, 20);
      step;
      wait_exec(n, 20);
      chk($sformatf("v%0d cycles", k), n + 1, vt[k].cyc);
      chk($sformatf("v%0d opr", k), inst_opr, vt[k].opr);
      chk($sformatf("v%0d operand", k), inst_operand, vt[k].opd);
      chk($sformatf("v%0d word2", k), inst_word2, vt[k].w2);
      step;
      chk($sformatf("v%0d pc", k), pc, vt[k].pc);
      chk($sformatf("v%0d next addr", k), mem_addr, vt[k].pc);
    end
    take_branch = 0;
    reg_is_zero = 0;
    mem[12'h000] = 8'h51; mem[12'h001] = 8'h00;
    mem[12'h100] = 8'h52; mem[12'h101] = 8'h00;
    mem[12'h200] = 8'h53; mem[12'h201] = 8'h00;
    mem[12'h300] = 8'h54; mem[12'h301] = 8'h00;
    mem[12'h400] = 8'hC0;
    mem[12'h102] = 8'hC0;
    mem[12'h202] = 8'hC0;
    mem[12'h302] = 8'hC0;
    do_reset;
    for (int j = 0; j < 4; j++) begin
      wait_exec(n, 20);
      step;
      chk($sformatf("jms%0d pc", j), pc, (j + 1) * 256);
      if (j == 2) chk("jms3 no fault", stack_fault, 0);
    end
    chk("jms4 fault", stack_fault, EXP_FAULT);
    ret = '{12'h302, 12'h202, 12'h102, 12'h302};
    for (int j = 0; j < 4; j++) begin
      wait_exec(n, 20);
      step;
      chk($sformatf("bbl%0d pc", j), pc, ret[j]);
    end
    reset = 0;
    repeat (2) step;
    chk("rst2 pc", pc, 0);
    chk("rst2 inst_opr", inst_opr, 0);
    chk("rst2 stack_fault", stack_fault, 0);
    chk("rst2 mem_read", mem_read, 0);
    reset = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
